// File: rtl/vsdma_frame_sched_if.sv
// vsdma request bus between the frame scheduler and the DMA engine.
`timescale 1ns/1ps
interface vsdma_frame_sched_if #(
    parameter int ADDR_WIDTH = 28
);
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wareq;
    logic [15:0]           wsize;
    logic                  wbusy;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  rareq;
    logic [15:0]           rsize;
    logic                  rbusy;

    modport master (
        output waddr, wareq, wsize,
        output raddr, rareq, rsize,
        input  wbusy, rbusy
    );

    modport slave (
        input  waddr, wareq, wsize,
        input  raddr, rareq, rsize,
        output wbusy, rbusy
    );
endinterface

// File: rtl/vsdma_frame_sched.sv
// Triple-buffer line sequencer for the vsdma write/read channels.
// Define VSDMA_SCHED_SERIAL_EN to serialise DDR ownership between channels.
`timescale 1ns/1ps
module vsdma_frame_sched #(
    parameter int          ADDR_WIDTH     = 28,
    parameter int          LINE_BEATS     = 240,
    parameter int          FRAME_LINES    = 1080,
    parameter int          BEAT_ADDR_INC  = 8,
    parameter int unsigned FB_BASE        = 0,
    parameter int unsigned FRAME_ADDR_INC = 32'h0400000
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESET,
    input  logic                wr_frame_start,
    input  logic [15:0]         wr_fifo_level,
    input  logic                rd_frame_start,
    input  logic [15:0]         rd_fifo_space,
    input  logic                err_clr,
    vsdma_frame_sched_if.master vsdma,
    output logic [1:0]          wr_buf_idx,
    output logic [1:0]          rd_buf_idx,
    output logic                frame_valid,
    output logic                wr_frame_err,
    output logic                rd_underrun_err
);
    localparam int LW = $clog2(FRAME_LINES + 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(FRAME_LINES - 1);
    localparam logic [LW-1:0] ONE_LINE = LW'(1);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP =
        ADDR_WIDTH'(LINE_BEATS * BEAT_ADDR_INC);
    localparam logic [ADDR_WIDTH-1:0] FB0 = ADDR_WIDTH'(FB_BASE);
    localparam logic [ADDR_WIDTH-1:0] FB1 = FB0 + ADDR_WIDTH'(FRAME_ADDR_INC);
    localparam logic [ADDR_WIDTH-1:0] FB2 = FB1 + ADDR_WIDTH'(FRAME_ADDR_INC);

    typedef enum logic [2:0] {W_IDLE, W_WAIT, W_REQ, W_ACK, W_BUSY} wr_st_t;
    typedef enum logic [2:0] {R_IDLE, R_WAIT, R_REQ, R_ACK, R_BUSY} rd_st_t;

    wr_st_t r_ws, w_ws_nxt;
    rd_st_t r_rs, w_rs_nxt;
    logic [LW-1:0] r_wline, r_rline;
    logic [ADDR_WIDTH-1:0] r_waddr, r_raddr;
    logic [1:0] r_widx, r_ridx, r_last;
    logic [1:0] w_widx_nxt, w_ridx_nxt, w_last_nxt, w_winc;
    logic r_wpend, r_rpend, r_wok, r_rok;
    logic r_fvalid, r_werr, r_rerr;
    logic w_wdone, w_rdone, w_commit, w_rend;
    logic w_wearly, w_rearly, w_wrestart, w_rrestart;
    logic w_wgo, w_rgo, w_wown, w_rown, w_fvalid_nxt;

    function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic [1:0] idx);
        unique case (1'b1)
            idx == 2'd1: return FB1;
            idx == 2'd2: return FB2;
            default:     return FB0;
        endcase
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    assign w_wdone  = (r_ws == W_BUSY) && !vsdma.wbusy;
    assign w_rdone  = (r_rs == R_BUSY) && !vsdma.rbusy;
    assign w_commit = w_wdone && (r_wline == LAST_LINE);
    assign w_rend   = w_rdone && (r_rline == LAST_LINE);
    assign w_wown   = r_ws inside {W_REQ, W_ACK, W_BUSY};
    assign w_rown   = r_rs inside {R_REQ, R_ACK, R_BUSY};

    // A start landing on the cycle the frame completes is not early.
    assign w_wearly = wr_frame_start && (r_ws != W_IDLE) && !w_commit;
    assign w_rearly = rd_frame_start && (r_rs != R_IDLE) && !w_rend;

    assign w_wrestart = (wr_frame_start && (r_ws inside {W_IDLE, W_WAIT}))
                     || (w_wdone && (r_wpend || wr_frame_start));
    assign w_rrestart = (rd_frame_start && (r_rs inside {R_IDLE, R_WAIT}))
                     || (w_rdone && (r_rpend || rd_frame_start));

`ifdef VSDMA_SCHED_SERIAL_EN
    assign w_rgo = (r_rs == R_WAIT) && r_rok && !rd_frame_start && !w_wown;
    assign w_wgo = (r_ws == W_WAIT) && r_wok && !wr_frame_start
                && !w_rown && !w_rgo;
`else
    assign w_rgo = (r_rs == R_WAIT) && r_rok && !rd_frame_start;
    assign w_wgo = (r_ws == W_WAIT) && r_wok && !wr_frame_start;
`endif

    // Commit resolves first so a same-cycle read start sees the new frame.
    assign w_last_nxt   = w_commit ? r_widx : r_last;
    assign w_fvalid_nxt = r_fvalid | w_commit;
    assign w_ridx_nxt   = !w_rrestart ? r_ridx
                        : (w_fvalid_nxt ? w_last_nxt : 2'd0);
    assign w_winc       = inc3(r_widx);
    assign w_widx_nxt   = !w_wrestart ? r_widx
                        : ((w_winc == w_ridx_nxt) ? inc3(w_winc) : w_winc);

    always_comb begin
        w_ws_nxt = r_ws;
        unique case (r_ws)
            W_IDLE: if (wr_frame_start) w_ws_nxt = W_WAIT;
            W_WAIT: if (w_wgo) w_ws_nxt = W_REQ;
            W_REQ:  w_ws_nxt = W_ACK;
            W_ACK:  if (vsdma.wbusy) w_ws_nxt = W_BUSY;
            W_BUSY: if (w_wdone)
                        w_ws_nxt = (w_commit && !w_wrestart) ? W_IDLE : W_WAIT;
            default: w_ws_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rs_nxt = r_rs;
        unique case (r_rs)
            R_IDLE: if (rd_frame_start) w_rs_nxt = R_WAIT;
            R_WAIT: if (w_rgo) w_rs_nxt = R_REQ;
            R_REQ:  w_rs_nxt = R_ACK;
            R_ACK:  if (vsdma.rbusy) w_rs_nxt = R_BUSY;
            R_BUSY: if (w_rdone)
                        w_rs_nxt = (w_rend && !w_rrestart) ? R_IDLE : R_WAIT;
            default: w_rs_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_ws    <= W_IDLE;
            r_wline <= '0;
            r_waddr <= '0;
            r_widx  <= 2'd0;
            r_wpend <= 1'b0;
            r_wok   <= 1'b0;
        end else begin
            r_ws   <= w_ws_nxt;
            r_widx <= w_widx_nxt;
            r_wok  <= (wr_fifo_level >= 16'(LINE_BEATS));
            if (w_wrestart) begin
                r_wline <= '0;
                r_waddr <= buf_base(w_widx_nxt);
            end else if (w_wdone) begin
                r_wline <= r_wline + ONE_LINE;
                r_waddr <= r_waddr + LINE_STEP;
            end
            if (w_wdone)
                r_wpend <= 1'b0;
            else if (w_wearly && (r_ws != W_WAIT))
                r_wpend <= 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_rs    <= R_IDLE;
            r_rline <= '0;
            r_raddr <= '0;
            r_ridx  <= 2'd0;
            r_rpend <= 1'b0;
            r_rok   <= 1'b0;
        end else begin
            r_rs   <= w_rs_nxt;
            r_ridx <= w_ridx_nxt;
            r_rok  <= (rd_fifo_space >= 16'(LINE_BEATS));
            if (w_rrestart) begin
                r_rline <= '0;
                r_raddr <= buf_base(w_ridx_nxt);
            end else if (w_rdone) begin
                r_rline <= r_rline + ONE_LINE;
                r_raddr <= r_raddr + LINE_STEP;
            end
            if (w_rdone)
                r_rpend <= 1'b0;
            else if (w_rearly && (r_rs != R_WAIT))
                r_rpend <= 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_last   <= 2'd0;
            r_fvalid <= 1'b0;
            r_werr   <= 1'b0;
            r_rerr   <= 1'b0;
        end else begin
            r_last   <= w_last_nxt;
            r_fvalid <= w_fvalid_nxt;
            if (err_clr)
                r_werr <= 1'b0;
            else if (w_wearly)
                r_werr <= 1'b1;
            if (err_clr)
                r_rerr <= 1'b0;
            else if (w_rearly)
                r_rerr <= 1'b1;
        end
    end

    assign vsdma.waddr     = r_waddr;
    assign vsdma.wareq     = (r_ws == W_REQ);
    assign vsdma.wsize     = 16'(LINE_BEATS);
    assign vsdma.raddr     = r_raddr;
    assign vsdma.rareq     = (r_rs == R_REQ);
    assign vsdma.rsize     = 16'(LINE_BEATS);
    assign wr_buf_idx      = r_widx;
    assign rd_buf_idx      = r_ridx;
    assign frame_valid     = r_fvalid;
    assign wr_frame_err    = r_werr;
    assign rd_underrun_err = r_rerr;
endmodule

// File: tb/tb_vsdma_frame_sched.sv
// Directed bench for vsdma_frame_sched: 4-line frames of 16 beats,
// DMA engine modelled as a fixed 20-cycle busy window per request.
`timescale 1ns/1ps
module tb_vsdma_frame_sched;
    localparam int AW = 28;
    localparam int LB = 16;
    localparam int FL = 4;
    localparam int BAI = 8;
    localparam int unsigned BASE = 32'h1000;
    localparam int unsigned FINC = 32'h0400000;
    localparam int BUSY_CYC = 20;
    localparam logic [31:0] B0 = BASE;
    localparam logic [31:0] B1 = BASE + FINC;
    localparam logic [31:0] B2 = BASE + 2 * FINC;
    localparam logic [31:0] STEP = LB * BAI;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_frame_start = 1'b0;
    logic rd_frame_start = 1'b0;
    logic err_clr = 1'b0;
    logic [15:0] wr_fifo_level = '0;
    logic [15:0] rd_fifo_space = '0;
    logic [1:0] wr_buf_idx, rd_buf_idx;
    logic frame_valid, wr_frame_err, rd_underrun_err;

    int n_chk = 0;
    int n_err = 0;

    logic m_wbusy = 1'b0;
    logic m_rbusy = 1'b0;
    int m_wcnt = 0;
    int m_rcnt = 0;
    int wreq_n = 0;
    int rreq_n = 0;
    int wide_n = 0;
    int ovl_n = 0;
    logic w_prev = 1'b0;
    logic r_prev = 1'b0;
    logic [31:0] wq[$];
    logic [31:0] rq[$];

    vsdma_frame_sched_if #(.ADDR_WIDTH(AW)) vif ();

    vsdma_frame_sched #(
        .ADDR_WIDTH(AW), .LINE_BEATS(LB), .FRAME_LINES(FL),
        .BEAT_ADDR_INC(BAI), .FB_BASE(BASE), .FRAME_ADDR_INC(FINC)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESET(rst),
        .wr_frame_start(wr_frame_start),
        .wr_fifo_level(wr_fifo_level),
        .rd_frame_start(rd_frame_start),
        .rd_fifo_space(rd_fifo_space),
        .err_clr(err_clr),
        .vsdma(vif),
        .wr_buf_idx(wr_buf_idx),
        .rd_buf_idx(rd_buf_idx),
        .frame_valid(frame_valid),
        .wr_frame_err(wr_frame_err),
        .rd_underrun_err(rd_underrun_err)
    );

    always #5 clk = ~clk;

    assign vif.wbusy = m_wbusy;
    assign vif.rbusy = m_rbusy;

    always @(posedge clk) begin
        if (rst) begin
            m_wbusy <= 1'b0;
            m_rbusy <= 1'b0;
            m_wcnt <= 0;
            m_rcnt <= 0;
        end else begin
            if (vif.wareq) begin
                m_wbusy <= 1'b1;
                m_wcnt <= BUSY_CYC;
                wq.push_back(32'(vif.waddr));
                wreq_n <= wreq_n + 1;
            end else if (m_wcnt > 0) begin
                m_wcnt <= m_wcnt - 1;
                if (m_wcnt == 1) m_wbusy <= 1'b0;
            end
            if (vif.rareq) begin
                m_rbusy <= 1'b1;
                m_rcnt <= BUSY_CYC;
                rq.push_back(32'(vif.raddr));
                rreq_n <= rreq_n + 1;
            end else if (m_rcnt > 0) begin
                m_rcnt <= m_rcnt - 1;
                if (m_rcnt == 1) m_rbusy <= 1'b0;
            end
            if ((vif.wareq && w_prev) || (vif.rareq && r_prev))
                wide_n <= wide_n + 1;
            if (m_wbusy && m_rbusy)
                ovl_n <= ovl_n + 1;
            w_prev <= vif.wareq;
            r_prev <= vif.rareq;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wstart();
        wr_frame_start = 1'b1;
        @(negedge clk);
        wr_frame_start = 1'b0;
    endtask

    task automatic rstart();
        rd_frame_start = 1'b1;
        @(negedge clk);
        rd_frame_start = 1'b0;
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_wframe(input int n, input string tag);
        int k = 0;
        while (k < 3000 && !(wreq_n >= n && !m_wbusy && !vif.wareq)) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_wdone"}, 32'(k < 3000), 1);
        tick(4);
    endtask

    task automatic wait_rframe(input int n, input string tag);
        int k = 0;
        while (k < 3000 && !(rreq_n >= n && !m_rbusy && !vif.rareq)) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_rdone"}, 32'(k < 3000), 1);
        tick(4);
    endtask

    task automatic wait_wbusy(input int n, input string tag);
        int k = 0;
        while (k < 3000 && !(wreq_n >= n && m_wbusy)) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_wbusy"}, 32'(k < 3000), 1);
    endtask

    task automatic wait_wreq(input int n, input string tag);
        int k = 0;
        while (k < 3000 && wreq_n < n) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_wreq"}, 32'(k < 3000), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        chk("rst_waddr", 32'(vif.waddr), 0);
        chk("rst_wareq", 32'(vif.wareq), 0);
        chk("rst_wsize", 32'(vif.wsize), LB);
        chk("rst_raddr", 32'(vif.raddr), 0);
        chk("rst_rareq", 32'(vif.rareq), 0);
        chk("rst_rsize", 32'(vif.rsize), LB);
        chk("rst_widx", 32'(wr_buf_idx), 0);
        chk("rst_ridx", 32'(rd_buf_idx), 0);
        chk("rst_fvalid", 32'(frame_valid), 0);
        chk("rst_werr", 32'(wr_frame_err), 0);
        chk("rst_rerr", 32'(rd_underrun_err), 0);
        rst = 1'b0;
        tick(2);

        // read start before any commit stays on buffer 0
        rstart();
        chk("t3a_ridx", 32'(rd_buf_idx), 0);
        chk("t3a_raddr", 32'(vif.raddr), B0);
        chk("t3a_rerr", 32'(rd_underrun_err), 0);

        // first write frame lands in buffer 1
        wr_fifo_level = 16'd16;
        tick(2);
        wstart();
        chk("t1_widx", 32'(wr_buf_idx), 1);
        chk("t1_lat_wait", 32'(vif.wareq), 0);
        chk("t1_waddr0", 32'(vif.waddr), B1);
        tick(1);
        chk("t1_lat_req", 32'(vif.wareq), 1);
        wait_wframe(4, "t1");
        chk("t1_nreq", 32'(wreq_n), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_addr%0d", i), wq[i], B1 + 32'(i) * STEP);
        chk("t1_fvalid", 32'(frame_valid), 1);

        // buffer rotation skips the buffer held by the reader
        wstart();
        chk("t2_idx_a", 32'(wr_buf_idx), 2);
        wait_wframe(8, "t2a");
        wstart();
        chk("t2_idx_b", 32'(wr_buf_idx), 1);
        wait_wframe(12, "t2b");
        chk("t2_addr_b", wq[8], B1);

        rstart();
        chk("t3_ridx_a", 32'(rd_buf_idx), 1);
        chk("t3_raddr_a", 32'(vif.raddr), B1);
        chk("t3_rerr_set", 32'(rd_underrun_err), 1);
        clr_err();
        chk("t3_rerr_clr", 32'(rd_underrun_err), 0);
        wstart();
        chk("t3_widx", 32'(wr_buf_idx), 2);
        wait_wframe(16, "t3");
        rstart();
        chk("t3_ridx_b", 32'(rd_buf_idx), 2);
        chk("t3_raddr_b", 32'(vif.raddr), B2);

        // early write start during line 2
        wstart();
        chk("t4_widx", 32'(wr_buf_idx), 0);
        wait_wbusy(19, "t4");
        wstart();
        chk("t4_werr", 32'(wr_frame_err), 1);
        chk("t4_idx_hold", 32'(wr_buf_idx), 0);
        wait_wreq(20, "t4");
        chk("t4_line2", wq[18], B0 + 2 * STEP);
        chk("t4_restart", wq[19], B1);
        chk("t4_widx_new", 32'(wr_buf_idx), 1);
        rstart();
        chk("t4_nocommit", 32'(rd_buf_idx), 2);
        clr_err();
        chk("t4_werr_clr", 32'(wr_frame_err), 0);
        chk("t4_rerr_clr", 32'(rd_underrun_err), 0);
        wait_wframe(23, "t4");
        chk("t4_nreq", 32'(wreq_n), 23);

        // FIFO threshold boundary
        wr_fifo_level = 16'd15;
        tick(2);
        wstart();
        chk("t5_widx", 32'(wr_buf_idx), 0);
        tick(10);
        chk("t5_hold", 32'(wreq_n), 23);
        wr_fifo_level = 16'd16;
        tick(1);
        chk("t5_lat1", 32'(vif.wareq), 0);
        tick(1);
        chk("t5_lat2", 32'(vif.wareq), 1);
        chk("t5_waddr", 32'(vif.waddr), B0);
        tick(1);
        chk("t5_width", 32'(vif.wareq), 0);
        wait_wframe(27, "t5");
        chk("t5_wide", 32'(wide_n), 0);

        // both channels become ready in the same cycle
        wr_fifo_level = 16'd0;
        tick(2);
        wstart();
        chk("t6_widx", 32'(wr_buf_idx), 1);
        tick(3);
        wr_fifo_level = 16'd16;
        rd_fifo_space = 16'd16;
        tick(2);
        chk("t6_rareq", 32'(vif.rareq), 1);
        chk("t6_raddr", 32'(vif.raddr), B2);
`ifdef VSDMA_SCHED_SERIAL_EN
        chk("t6_wareq_held", 32'(vif.wareq), 0);
`else
        chk("t6_wareq_par", 32'(vif.wareq), 1);
`endif
        wait_rframe(4, "t6");
        wait_wframe(31, "t6");
        chk("t6_rline3", rq[3], B2 + 3 * STEP);
        chk("t6_wline0", wq[27], B1);
`ifdef VSDMA_SCHED_SERIAL_EN
        chk("t6_overlap", 32'(ovl_n), 0);
`else
        chk("t6_overlap", 32'(ovl_n > 0), 1);
`endif
        chk("t6_wide", 32'(wide_n), 0);
        rstart();
        chk("t6_ridx", 32'(rd_buf_idx), 1);
        chk("t6_raddr_new", 32'(vif.raddr), B1);
        chk("t6_rerr_idle", 32'(rd_underrun_err), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
